// File: rtl/tty_seq_if.sv
// tty_seq_if: byte-stream and framebuffer port-b bundle for the glass-TTY sequencer.
//   ch_valid/ch_data/ch_ready   byte stream with valid/ready handshake
//   attr_fg_vld/attr_fg/attr_bg colour attributes sampled with each byte
//   fb_enb/fb_web/fb_addrb/fb_dinb framebuffer port-b write bus
// Modports: master = byte source / framebuffer side, slave = the sequencer.
interface tty_seq_if;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        attr_fg_vld;
    logic [3:0]  attr_fg;
    logic [2:0]  attr_bg;
    logic        fb_enb;
    logic [7:0]  fb_web;
    logic [11:0] fb_addrb;
    logic [63:0] fb_dinb;

    modport master (
        output ch_valid, ch_data, attr_fg_vld, attr_fg, attr_bg,
        input  ch_ready, fb_enb, fb_web, fb_addrb, fb_dinb
    );
    modport slave (
        input  ch_valid, ch_data, attr_fg_vld, attr_fg, attr_bg,
        output ch_ready, fb_enb, fb_web, fb_addrb, fb_dinb
    );
endinterface

// File: rtl/tty_seq.sv
// tty_seq: glass-TTY sequencer driving the text-mode framebuffer write port.
// Turns a byte stream into 16-bit cell writes into a 32x128 character RAM
// (cell = {1'b0, bg[2:0], fg[3:0], ascii[7:0]}, replicated 4x per 64-bit word),
// and keeps the hardware cursor and scroll (top-row) control registers updated.
// Ports:
//   clk_data    clock, rising edge
//   rstn        asynchronous active-low reset
//   bus         tty_seq_if.slave: byte handshake, attributes, fb port-b bus
//   cur_x       cursor column
//   cur_y       cursor screen row (0 = top of display)
//   scroll_top  physical RAM row shown at top
// Optional build macro TTY_AUTOWRAP_EN: a printable at column 127 wraps with
// an implicit CR+LF (scrolling at the bottom row) instead of sticking at 127.
module tty_seq #(
    parameter int         TAB_W  = 8,
    parameter logic [3:0] DEF_FG = 4'h7,
    parameter logic [2:0] DEF_BG = 3'h0
) (
    input  logic       clk_data,
    input  logic       rstn,
    tty_seq_if.slave   bus,
    output logic [6:0] cur_x,
    output logic [4:0] cur_y,
    output logic [4:0] scroll_top
);
    typedef enum logic [2:0] {IDLE, PUT, CLRL, CLRS, SCR, CURX, CURY} state_t;

    state_t      state;
    logic        rdy;
    logic        enb;
    logic [7:0]  web;
    logic [11:0] addr;
    logic [63:0] din;
    logic [3:0]  fg_q;
    logic [2:0]  bg_q;
    logic [4:0]  clr_row;
    logic [9:0]  widx;
`ifdef TTY_AUTOWRAP_EN
    logic        wrap_scr;
`endif

    function automatic logic [11:0] ctl_addr(input logic [1:0] sel);
        return {1'b1, 9'b0, sel};
    endfunction

    function automatic logic [63:0] ctl_data(input logic [6:0] d);
        return {57'b0, d};
    endfunction

    function automatic logic [63:0] blank(input logic [3:0] f, input logic [2:0] b);
        return {4{1'b0, b, f, 8'h20}};
    endfunction

    logic [4:0] pr;
    logic [3:0] in_fg;
    logic [2:0] in_bg;
    logic [7:0] tab_sum;
    logic [6:0] tab_x;
    logic [6:0] nx;
    logic       hs;
    logic       printable;

    assign pr        = scroll_top + cur_y;
    assign in_fg     = bus.attr_fg_vld ? bus.attr_fg : DEF_FG;
    assign in_bg     = bus.attr_fg_vld ? bus.attr_bg : DEF_BG;
    // 8-bit sum so the step past column 127 is visible and clamped
    assign tab_sum   = {1'b0, cur_x | 7'(TAB_W - 1)} + 8'd1;
    assign tab_x     = tab_sum[7] ? 7'd127 : tab_sum[6:0];
    assign hs        = bus.ch_valid && rdy;
    assign printable = (bus.ch_data >= 8'h20) && (bus.ch_data <= 8'h7E);

    // New column for the pure cursor-motion bytes
    always_comb begin
        nx = cur_x;
        case (bus.ch_data)
            8'h0D:   nx = 7'd0;
            8'h08:   nx = (cur_x == 7'd0) ? cur_x : cur_x - 7'd1;
            8'h09:   nx = tab_x;
            default: nx = cur_x;
        endcase
    end

    // Each branch sets the write that is visible in the following cycle.
    // Cursor/scroll updates land on the same edge as the write that uses the
    // old values, so later control writes just read the registers.
    always_ff @(posedge clk_data or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            rdy        <= 1'b0;
            enb        <= 1'b0;
            web        <= 8'h00;
            addr       <= 12'h000;
            din        <= 64'h0;
            cur_x      <= 7'd0;
            cur_y      <= 5'd0;
            scroll_top <= 5'd0;
            fg_q       <= 4'h0;
            bg_q       <= 3'h0;
            clr_row    <= 5'd0;
            widx       <= 10'd0;
`ifdef TTY_AUTOWRAP_EN
            wrap_scr   <= 1'b0;
`endif
        end else begin
            enb <= 1'b0;
            web <= 8'h00;
            case (state)
                IDLE: begin
                    rdy <= 1'b1;
                    if (hs) begin
                        fg_q <= in_fg;
                        bg_q <= in_bg;
                        if (printable) begin
                            rdy   <= 1'b0;
                            state <= PUT;
                            {enb, web} <= {1'b1, 8'h03 << {cur_x[1:0], 1'b0}};
                            addr  <= {2'b00, pr, cur_x[6:2]};
                            din   <= {4{1'b0, in_bg, in_fg, bus.ch_data}};
`ifdef TTY_AUTOWRAP_EN
                            wrap_scr <= 1'b0;
                            if (cur_x == 7'd127) begin
                                cur_x <= 7'd0;
                                if (cur_y != 5'd31) begin
                                    cur_y <= cur_y + 5'd1;
                                end else begin
                                    scroll_top <= scroll_top + 5'd1;
                                    clr_row    <= scroll_top;
                                    wrap_scr   <= 1'b1;
                                end
                            end else begin
                                cur_x <= cur_x + 7'd1;
                            end
`else
                            if (cur_x != 7'd127) cur_x <= cur_x + 7'd1;
`endif
                        end else begin
                            case (bus.ch_data)
                                8'h0D, 8'h08, 8'h09: begin
                                    rdy   <= 1'b0;
                                    cur_x <= nx;
                                    state <= CURX;
                                    {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b10), ctl_data(nx)};
                                end
                                8'h0A: begin
                                    rdy <= 1'b0;
                                    if (cur_y != 5'd31) begin
                                        cur_y <= cur_y + 5'd1;
                                        state <= CURX;
                                        {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b10), ctl_data(cur_x)};
                                    end else begin
                                        // old top row becomes the new bottom row
                                        scroll_top <= scroll_top + 5'd1;
                                        clr_row    <= scroll_top;
                                        widx       <= 10'd0;
                                        state      <= CLRL;
                                        {enb, web, addr, din} <= {1'b1, 8'hFF, 2'b00, scroll_top, 5'd0, blank(in_fg, in_bg)};
                                    end
                                end
                                8'h0C: begin
                                    rdy   <= 1'b0;
                                    widx  <= 10'd0;
                                    state <= CLRS;
                                    {enb, web, addr, din} <= {1'b1, 8'hFF, 12'h000, blank(in_fg, in_bg)};
                                end
                                default: ;  // accepted and dropped
                            endcase
                        end
                    end
                end
                PUT: begin
`ifdef TTY_AUTOWRAP_EN
                    if (wrap_scr) begin
                        wrap_scr <= 1'b0;
                        widx     <= 10'd0;
                        state    <= CLRL;
                        {enb, web, addr, din} <= {1'b1, 8'hFF, 2'b00, clr_row, 5'd0, blank(fg_q, bg_q)};
                    end else begin
                        state <= CURX;
                        {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b10), ctl_data(cur_x)};
                    end
`else
                    state <= CURX;
                    {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b10), ctl_data(cur_x)};
`endif
                end
                CLRL: begin
                    if (widx[4:0] == 5'd31) begin
                        state <= SCR;
                        {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b00), ctl_data({2'b00, scroll_top})};
                    end else begin
                        widx <= widx + 10'd1;
                        {enb, web, addr, din} <= {1'b1, 8'hFF, 2'b00, clr_row, widx[4:0] + 5'd1, blank(fg_q, bg_q)};
                    end
                end
                CLRS: begin
                    if (widx == 10'd1023) begin
                        cur_x      <= 7'd0;
                        cur_y      <= 5'd0;
                        scroll_top <= 5'd0;
                        state      <= SCR;
                        {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b00), ctl_data(7'd0)};
                    end else begin
                        widx <= widx + 10'd1;
                        {enb, web, addr, din} <= {1'b1, 8'hFF, 2'b00, widx + 10'd1, blank(fg_q, bg_q)};
                    end
                end
                SCR: begin
                    state <= CURX;
                    {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b10), ctl_data(cur_x)};
                end
                CURX: begin
                    state <= CURY;
                    {enb, web, addr, din} <= {1'b1, 8'h01, ctl_addr(2'b11), ctl_data({2'b00, pr})};
                end
                CURY: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ch_ready = rdy;
    assign bus.fb_enb   = enb;
    assign bus.fb_web   = web;
    assign bus.fb_addrb = addr;
    assign bus.fb_dinb  = din;
endmodule
